// File: rtl/freq_pkg.sv
// -----------------------------------------------------------------------------
// freq_pkg
// Shared definitions for the multi-channel divided-clock generator:
//   - chan_state_t : per-channel enable/stop FSM state
//   - DEF_*        : default channel count, counter width and reset half-period
//   - wr_ch_width  : width of the write channel-index port (at least 1 bit)
// -----------------------------------------------------------------------------
package freq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } chan_state_t;

    localparam int DEF_NCH  = 32'sd3;
    localparam int DEF_CW   = 32'sd24;
    localparam int DEF_HALF = 32'sd10;

    // A single-channel build still needs a 1-bit index port.
    function automatic int wr_ch_width(input int nch);
        if (nch <= 32'sd1) begin
            return 32'sd1;
        end else begin
            return $clog2(nch);
        end
    endfunction

endpackage

// File: rtl/freq_chan.sv
// -----------------------------------------------------------------------------
// freq_chan
// One divided-clock channel: half-period counter, shadowed divisor and the
// IDLE/RUN/DRAIN enable FSM. The output toggles when the counter reaches the
// active half-period, giving a period of 2*(half+1) clock cycles.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_rst      asynchronous active-high reset
//   i_en       run enable for this channel
//   i_sync     phase-resync pulse (affects RUN/DRAIN only)
//   i_wr       divisor write strobe, already decoded for this channel
//   i_wr_half  new half-period value
//   o_oclk     divided clock (registered)
//   o_tick     one-cycle pulse on every o_oclk toggle (registered)
//   o_run      channel is counting (RUN or DRAIN, registered)
// -----------------------------------------------------------------------------
module freq_chan
    import freq_pkg::*;
#(
    parameter int            CW          = DEF_CW,
    parameter logic [CW-1:0] RST_HALF_CH = CW'(DEF_HALF)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_sync,
    input  logic          i_wr,
    input  logic [CW-1:0] i_wr_half,
    output logic          o_oclk,
    output logic          o_tick,
    output logic          o_run
);

    localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

    chan_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_half;
    logic [CW-1:0] r_shd;
    logic          r_pnd;
    logic          r_oclk;
    logic          r_tick;
    logic          r_run;

    logic          w_tc;

    // Terminal count: equality only, the counter is never allowed past r_half.
    assign w_tc = (r_cnt == r_half);

    // Channel FSM, counter, shadow divisor and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
            r_half  <= RST_HALF_CH;
            r_shd   <= RST_HALF_CH;
            r_pnd   <= 1'b0;
            r_oclk  <= 1'b0;
            r_tick  <= 1'b0;
            r_run   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt  <= CNT_ZERO;
                    r_oclk <= 1'b0;
                    // A stopped channel takes a new divisor at once; a value
                    // left pending by the final drain toggle is flushed here.
                    if (i_wr) begin
                        r_half <= i_wr_half;
                        r_shd  <= i_wr_half;
                        r_pnd  <= 1'b0;
                    end else if (r_pnd) begin
                        r_half <= r_shd;
                        r_pnd  <= 1'b0;
                    end else begin
                        r_pnd  <= 1'b0;
                    end
                    if (i_en) begin
                        r_state <= ST_RUN;
                        r_run   <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_run   <= 1'b0;
                    end
                end

                ST_RUN, ST_DRAIN: begin
                    if (i_sync) begin
                        // Resync: restart low, no tick, commit any divisor
                        // (including one written in this same cycle).
                        r_cnt  <= CNT_ZERO;
                        r_oclk <= 1'b0;
                        r_pnd  <= 1'b0;
                        if (i_wr) begin
                            r_half <= i_wr_half;
                            r_shd  <= i_wr_half;
                        end else if (r_pnd) begin
                            r_half <= r_shd;
                        end else begin
                            r_half <= r_half;
                        end
                        if (r_state == ST_DRAIN) begin
                            r_state <= ST_IDLE;
                            r_run   <= 1'b0;
                        end else begin
                            r_state <= ST_RUN;
                            r_run   <= 1'b1;
                        end
                    end else if (!i_en && !r_oclk) begin
                        // Output already low: stop immediately.
                        r_state <= ST_IDLE;
                        r_run   <= 1'b0;
                        r_cnt   <= CNT_ZERO;
                        if (i_wr) begin
                            r_shd <= i_wr_half;
                            r_pnd <= 1'b1;
                        end else begin
                            r_pnd <= r_pnd;
                        end
                    end else begin
                        if (w_tc) begin
                            r_cnt  <= CNT_ZERO;
                            r_oclk <= ~r_oclk;
                            r_tick <= 1'b1;
                            if (r_pnd) begin
                                r_half <= r_shd;
                            end else begin
                                r_half <= r_half;
                            end
                            // Without EN the output was high here, so this
                            // toggle is the falling edge that ends the drain.
                            if (i_en) begin
                                r_state <= ST_RUN;
                                r_run   <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                                r_run   <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                            if (i_en) begin
                                r_state <= ST_RUN;
                            end else begin
                                r_state <= ST_DRAIN;
                            end
                            r_run <= 1'b1;
                        end
                        // A write racing a terminal count waits for the next one.
                        if (i_wr) begin
                            r_shd <= i_wr_half;
                            r_pnd <= 1'b1;
                        end else if (w_tc) begin
                            r_pnd <= 1'b0;
                        end else begin
                            r_pnd <= r_pnd;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= CNT_ZERO;
                    r_oclk  <= 1'b0;
                    r_run   <= 1'b0;
                    r_pnd   <= 1'b0;
                end
            endcase
        end
    end

    assign o_oclk = r_oclk;
    assign o_tick = r_tick;
    assign o_run  = r_run;

endmodule

// File: rtl/freq_gen.sv
// -----------------------------------------------------------------------------
// freq_gen
// Multi-channel divided-clock / tick generator. Decodes the divisor write to
// one channel, fans the resync pulse out to all channels and instantiates NCH
// independent freq_chan channels.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_rst      asynchronous active-high reset
//   i_en       per-channel run enable [NCH]
//   i_sync     one-cycle resync pulse for all running channels
//   i_wr       divisor write strobe
//   i_wr_ch    write channel index; indices >= NCH are ignored
//   i_wr_half  new half-period value [CW]
//   o_oclk     divided clock per channel [NCH]
//   o_tick     one-cycle pulse on every o_oclk toggle [NCH]
//   o_run      channel is actively counting [NCH]
// -----------------------------------------------------------------------------
module freq_gen
    import freq_pkg::*;
#(
    parameter int                  NCH      = DEF_NCH,
    parameter int                  CW       = DEF_CW,
    parameter logic [NCH*CW-1:0]   RST_HALF = {NCH{CW'(DEF_HALF)}},
    localparam int                 WCHW     = wr_ch_width(NCH)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NCH-1:0]  i_en,
    input  logic            i_sync,
    input  logic            i_wr,
    input  logic [WCHW-1:0] i_wr_ch,
    input  logic [CW-1:0]   i_wr_half,
    output logic [NCH-1:0]  o_oclk,
    output logic [NCH-1:0]  o_tick,
    output logic [NCH-1:0]  o_run
);

    logic [NCH-1:0] w_wr_sel;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        // Only indices that name a real channel can match, so an
        // out-of-range write selects nothing.
        assign w_wr_sel[gi] = i_wr & (i_wr_ch == WCHW'(gi));

        freq_chan #(
            .CW          (CW),
            .RST_HALF_CH (RST_HALF[gi*CW +: CW])
        ) u_chan (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_en      (i_en[gi]),
            .i_sync    (i_sync),
            .i_wr      (w_wr_sel[gi]),
            .i_wr_half (i_wr_half),
            .o_oclk    (o_oclk[gi]),
            .o_tick    (o_tick[gi]),
            .o_run     (o_run[gi])
        );
    end

endmodule

// File: tb/tb_freq_gen.sv
// -----------------------------------------------------------------------------
// tb_freq_gen
// Directed self-checking bench for freq_gen (NCH=3, CW=24, reset half=10).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_freq_gen;
    import freq_pkg::*;

    localparam int NCH  = 3;
    localparam int CW   = 24;
    localparam int WCHW = wr_ch_width(NCH);

    logic            clk;
    logic            rst;
    logic [NCH-1:0]  en;
    logic            sync;
    logic            wr;
    logic [WCHW-1:0] wr_ch;
    logic [CW-1:0]   wr_half;
    logic [NCH-1:0]  o_oclk;
    logic [NCH-1:0]  o_tick;
    logic [NCH-1:0]  o_run;

    int total_cnt;
    int bad_cnt;

    freq_gen #(
        .NCH (NCH),
        .CW  (CW)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_sync    (sync),
        .i_wr      (wr),
        .i_wr_ch   (wr_ch),
        .i_wr_half (wr_half),
        .o_oclk    (o_oclk),
        .o_tick    (o_tick),
        .o_run     (o_run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until channel ch ticks (or the limit runs out); n = cycles taken.
    task automatic wait_tick(input int ch, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!o_tick[ch] && n < limit);
    endtask

    task automatic write_div(input int ch, input int half);
        wr      = 1'b1;
        wr_ch   = WCHW'(ch);
        wr_half = CW'(half);
        step();
        wr      = 1'b0;
    endtask

    int n;
    int n0;
    int n1;

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst     = 1'b1;
        en      = '0;
        sync    = 1'b0;
        wr      = 1'b0;
        wr_ch   = '0;
        wr_half = '0;

        // Reset state
        step();
        step();
        check_eq("rst_oclk", 32'(o_oclk), 32'd0);
        check_eq("rst_run",  32'(o_run),  32'd0);
        rst = 1'b0;
        step();
        check_eq("idle_tick", 32'(o_tick), 32'd0);

        // Channel 0 alone at half=10: ticks every 11 cycles
        en = 3'b001;
        step();
        check_eq("start_run", 32'(o_run), 32'd1);
        check_eq("start_oclk", 32'(o_oclk), 32'd0);
        wait_tick(0, 50, n);
        check_eq("first_tick", n, 32'd11);
        check_eq("first_rise", 32'(o_oclk), 32'd1);
        wait_tick(0, 50, n);
        check_eq("tick2", n, 32'd11);
        check_eq("fall", 32'(o_oclk), 32'd0);
        wait_tick(0, 50, n);
        check_eq("tick3", n, 32'd11);
        check_eq("others_quiet", 32'({o_run[2:1], o_oclk[2:1]}), 32'd0);

        // Shadowed write of half=4, 4 cycles into a half-period
        step();
        step();
        step();
        write_div(0, 4);
        wait_tick(0, 50, n);
        check_eq("shd_cur_half", n, 32'd7);
        check_eq("shd_cur_oclk", 32'(o_oclk[0]), 32'd0);
        wait_tick(0, 50, n);
        check_eq("shd_new_half", n, 32'd5);
        wait_tick(0, 50, n);
        check_eq("shd_new_half2", n, 32'd5);

        // Restore half=10 (lands during a 5-cycle half-period)
        write_div(0, 10);
        wait_tick(0, 50, n);
        check_eq("restore_a", n, 32'd4);
        check_eq("restore_oclk", 32'(o_oclk[0]), 32'd1);
        wait_tick(0, 50, n);
        check_eq("restore_b", n, 32'd11);
        wait_tick(0, 50, n);
        check_eq("restore_c", n, 32'd11);
        check_eq("pre_drain_oclk", 32'(o_oclk[0]), 32'd1);

        // Drop EN two cycles after a rise: drain until the falling edge
        step();
        step();
        en = 3'b000;
        step();
        check_eq("drain_run", 32'(o_run[0]), 32'd1);
        wait_tick(0, 50, n);
        check_eq("drain_len", n, 32'd8);
        check_eq("drain_oclk", 32'(o_oclk[0]), 32'd0);
        check_eq("drain_stop", 32'(o_run[0]), 32'd0);
        repeat (5) step();
        check_eq("stopped", 32'({o_run, o_oclk, o_tick}), 32'd0);

        // Two channels at half 3 and 5, different phases, then SYNC
        write_div(0, 3);
        write_div(1, 5);
        en = 3'b001;
        step();
        step();
        step();
        en = 3'b011;
        repeat (6) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check_eq("sync_oclk", 32'(o_oclk), 32'd0);
        check_eq("sync_tick", 32'(o_tick), 32'd0);
        check_eq("sync_run", 32'(o_run), 32'd3);
        n0 = 0;
        n1 = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (o_tick[0] && n0 == 0) n0 = i;
            if (o_tick[1] && n1 == 0) n1 = i;
        end
        check_eq("sync_t0", n0, 32'd4);
        check_eq("sync_t1", n1, 32'd6);
        check_eq("sync_phase", 32'(o_oclk[1:0]), 32'd2);

        // Async reset with channel 1 high, no clock edge involved
        rst = 1'b1;
        #2;
        check_eq("arst_oclk", 32'(o_oclk), 32'd0);
        check_eq("arst_run", 32'(o_run), 32'd0);
        #1;
        rst = 1'b0;
        en  = 3'b011;
        step();
        n0 = 0;
        n1 = 0;
        for (int i = 1; i <= 11; i++) begin
            step();
            if (o_tick[0] && n0 == 0) n0 = i;
            if (o_tick[1] && n1 == 0) n1 = i;
        end
        check_eq("rst_half0", n0, 32'd11);
        check_eq("rst_half1", n1, 32'd11);

        // Out-of-range write index touches nothing
        write_div(3, 2);
        wait_tick(0, 50, n);
        check_eq("oor_ch0_a", n, 32'd10);
        check_eq("oor_ch1_sync", 32'(o_tick[1]), 32'd1);
        wait_tick(0, 50, n);
        check_eq("oor_ch0_b", n, 32'd11);
        en = 3'b100;
        step();
        wait_tick(2, 50, n);
        check_eq("oor_ch2", n, 32'd11);
        en = 3'b000;
        n = 0;
        while (o_run != 3'b000 && n < 40) begin
            step();
            n++;
        end
        check_eq("all_stop", 32'(o_run), 32'd0);
        check_eq("all_low", 32'(o_oclk), 32'd0);

        // half=0 on a stopped channel: CLK/2
        write_div(2, 0);
        en = 3'b100;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("div2_tick", 32'(o_tick[2]), 32'd1);
            check_eq("div2_oclk", 32'(o_oclk[2]), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        en = 3'b000;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
